// File: rtl/branch_pc_unit.sv
// LC-3 program counter with BR resolution.
// Fetch increments; BR loads PC + sext(offset9) when BEN is set.
module branch_pc_unit #(
  parameter logic [15:0] RESET_PC = 16'h3000,
  parameter int          CNT_W    = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Fetch,
  input  logic             Br_start,
  input  logic [15:0]      IR,
  input  logic             BEN_in,
  output logic [15:0]      PC,
  output logic             Busy,
  output logic             Done,
  output logic             Taken,
  output logic [CNT_W-1:0] Taken_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] offset;
  logic        is_idle;
  logic        br_go;
  logic        cnt_full;

  assign is_idle  = (state == IDLE);
  assign br_go    = is_idle && Br_start && (IR[15:12] == 4'b0000);
  assign cnt_full = (Taken_cnt == {CNT_W{1'b1}});
  assign Busy     = !is_idle;
  assign Done     = (state == UPDATE);

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: IDLE -> EVAL -> UPDATE -> IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (br_go) state_nxt = EVAL;
      EVAL:    state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Offset latch: sign-extended offset9 captured when a BR is accepted
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)      offset <= 16'h0000;
    else if (br_go) offset <= {{7{IR[8]}}, IR[8:0]};
  end

  // PC: fetch increments in IDLE, taken branch adds offset in UPDATE
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                  PC <= RESET_PC;
    else if (is_idle && Fetch)  PC <= PC + 16'd1;
    else if (Done && Taken)     PC <= PC + offset;
  end

  // Branch outcome sampled from BEN at the end of EVAL
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)              Taken <= 1'b0;
    else if (state == EVAL) Taken <= BEN_in;
  end

  // Saturating count of taken branches
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                          Taken_cnt <= '0;
    else if (Done && Taken && !cnt_full) Taken_cnt <= Taken_cnt + 1'b1;
  end

endmodule
